// File: rtl/tick_counter.sv
// Prescaled enable tick driving a run/stop controlled up/down wrap counter.
// Single clock domain; the tick is a one-cycle enable, never a derived clock.
module tick_counter #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 10,
    parameter int MAX_COUNT   = 9999,
    parameter int CNT_W       = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run_stop,
    input  logic             i_clear,
    input  logic             i_mode,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tick,
    output logic             o_wrap,
    output logic             o_running
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  prescaler_q, prescaler_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              tick_q, tick_d;
    logic              wrap_q, wrap_d;
    logic              running_q, running_d;
    logic              rs_q, clr_q;
    logic              rs_edge, clr_edge;

    // The tick cycle is completed even when a stop or clear request arrives on it.
    always_comb begin
        rs_edge     = i_run_stop & ~rs_q;
        clr_edge    = i_clear & ~clr_q;
        state_d     = state_q;
        prescaler_d = prescaler_q;
        count_d     = count_q;
        tick_d      = 1'b0;
        wrap_d      = 1'b0;

        case (state_q)
            ST_STOP: begin
                if (clr_edge) begin
                    state_d = ST_CLEAR;
                end else if (rs_edge) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (prescaler_q == PRE_LAST) begin
                    prescaler_d = '0;
                    tick_d      = 1'b1;
                    if (i_mode) begin
                        if (count_q == '0) begin
                            count_d = CNT_MAX;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end else begin
                        if (count_q == CNT_MAX) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end
                end else begin
                    prescaler_d = prescaler_q + PRE_ONE;
                end

                if (clr_edge) begin
                    state_d = ST_CLEAR;
                end else if (rs_edge) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLEAR: begin
                count_d     = '0;
                prescaler_d = '0;
                state_d     = ST_STOP;
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_STOP;
            prescaler_q <= '0;
            count_q     <= '0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            running_q   <= 1'b0;
            rs_q        <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            count_q     <= count_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
            running_q   <= running_d;
            rs_q        <= i_run_stop;
            clr_q       <= i_clear;
        end
    end

    assign o_count   = count_q;
    assign o_tick    = tick_q;
    assign o_wrap    = wrap_q;
    assign o_running = running_q;

endmodule
